// File: rtl/tm_pkg.sv
// Shared types for the programmable binary Turing machine: move codes,
// controller states, transition-table entry layout and the default tape home cell.
package tm_pkg;

    localparam int TAPE_LEN_DEF = 64;
    localparam int HOME         = TAPE_LEN_DEF / 2;
    localparam int MAX_DATA_W   = 8;

    typedef enum logic [1:0] {
        MV_LEFT  = 2'd0,
        MV_RIGHT = 2'd1,
        MV_HALT  = 2'd2,
        MV_STAY  = 2'd3
    } tm_move_e;

    typedef enum logic [2:0] {
        LOAD_N,
        LOAD_TBL,
        LOAD_TAPE,
        RUN,
        HALT
    } tm_state_e;

    // next is stored at the widest supported word so the struct is not parameterized
    typedef struct packed {
        logic                  wr;
        tm_move_e              mv;
        logic [MAX_DATA_W-1:0] nxt;
    } tm_entry_t;

    localparam tm_entry_t ENTRY_RST = '{wr: 1'b0, mv: MV_HALT, nxt: '0};

endpackage

// File: rtl/tm_edge_detect.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of a level input.
module tm_edge_detect (
    input  logic clock,
    input  logic Reset_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) d_q <= 1'b0;
        else          d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/turing_machine.sv
// Single-tape binary Turing machine: keyed-in program/tape, single-stepped by Next.
// Optional build macro TM_TAPE_WRAP_EN makes the head and display window wrap around the tape.
module turing_machine
    import tm_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int TAPE_LEN = 64
) (
    input  logic              clock,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] input_data,
    input  logic              Next,
    input  logic              Done,
    output logic [10:0]       display,
    output logic              Compute_done
);

    localparam int MAX_ST  = (1 << DATA_W) - 1;
    localparam int NUM_ENT = 2 * MAX_ST;
    localparam int HW      = $clog2(TAPE_LEN);
    localparam int IW      = DATA_W + 1;
    localparam logic [HW-1:0] HOME_POS = HW'(TAPE_LEN / 2);

    logic nxt_ev, done_ev;

    tm_edge_detect u_next_ed (.clock(clock), .Reset_n(Reset_n), .d(Next), .pulse(nxt_ev));
    tm_edge_detect u_done_ed (.clock(clock), .Reset_n(Reset_n), .d(Done), .pulse(done_ev));

    tm_state_e             fsm_q, fsm_d;
    logic [DATA_W-1:0]     n_q, n_d;
    logic [IW-1:0]         ent_q, ent_d;
    logic [1:0]            phase_q, phase_d;
    logic [HW:0]           tptr_q, tptr_d;
    logic [TAPE_LEN-1:0]   tape_q, tape_d;
    tm_entry_t             tbl_q [NUM_ENT];
    tm_entry_t             tbl_d [NUM_ENT];
    logic [HW-1:0]         head_q, head_d;
    logic [DATA_W-1:0]     st_q, st_d;

    logic [IW-1:0]         last_ent;
    logic [IW-1:0]         run_idx;
    tm_entry_t             cur;
    logic                  halt;

    always_comb begin
        fsm_d    = fsm_q;
        n_d      = n_q;
        ent_d    = ent_q;
        phase_d  = phase_q;
        tptr_d   = tptr_q;
        tape_d   = tape_q;
        tbl_d    = tbl_q;
        head_d   = head_q;
        st_d     = st_q;
        last_ent = {n_q, 1'b0} - IW'(1);
        run_idx  = {st_q - DATA_W'(1), tape_q[head_q]};
        cur      = tbl_q[run_idx];
        halt     = 1'b0;

        case (fsm_q)
            LOAD_N: if (nxt_ev) begin
                n_d   = (input_data == '0) ? DATA_W'(1) : input_data;
                fsm_d = LOAD_TBL;
            end
            LOAD_TBL: if (nxt_ev) begin
                // each entry arrives as three words: write, move, next
                case (phase_q)
                    2'd0:    tbl_d[ent_q].wr  = input_data[0];
                    2'd1:    tbl_d[ent_q].mv  = tm_move_e'(input_data[1:0]);
                    default: tbl_d[ent_q].nxt = MAX_DATA_W'(input_data);
                endcase
                if (phase_q == 2'd2) begin
                    phase_d = 2'd0;
                    ent_d   = ent_q + IW'(1);
                    if (ent_q == last_ent) fsm_d = LOAD_TAPE;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            LOAD_TAPE: if (nxt_ev && tptr_q < (HW+1)'(TAPE_LEN)) begin
                tape_d[tptr_q[HW-1:0]] = input_data[0];
                tptr_d = tptr_q + (HW+1)'(1);
            end
            RUN: if (nxt_ev) begin
                tape_d[head_q] = cur.wr;
                case (cur.mv)
                    MV_LEFT:
                        if (head_q == '0)
`ifdef TM_TAPE_WRAP_EN
                            head_d = HW'(TAPE_LEN - 1);
`else
                            halt = 1'b1;
`endif
                        else head_d = head_q - HW'(1);
                    MV_RIGHT:
                        if (head_q == HW'(TAPE_LEN - 1))
`ifdef TM_TAPE_WRAP_EN
                            head_d = '0;
`else
                            halt = 1'b1;
`endif
                        else head_d = head_q + HW'(1);
                    MV_HALT: halt = 1'b1;
                    default: ;
                endcase
                if (cur.nxt == '0 || cur.nxt > MAX_DATA_W'(n_q)) halt = 1'b1;
                if (halt) fsm_d = HALT;
                else      st_d  = cur.nxt[DATA_W-1:0];
            end
            default: ;
        endcase

        // Done after any same-cycle Next load, so the last word still lands
        if (done_ev && (fsm_q == LOAD_N || fsm_q == LOAD_TBL || fsm_q == LOAD_TAPE)) begin
            fsm_d  = RUN;
            head_d = HOME_POS;
            st_d   = DATA_W'(1);
        end
    end

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm_q   <= LOAD_N;
            n_q     <= DATA_W'(1);
            ent_q   <= '0;
            phase_q <= '0;
            tptr_q  <= (HW+1)'(TAPE_LEN / 2);
            tape_q  <= '0;
            head_q  <= HOME_POS;
            st_q    <= DATA_W'(1);
            for (int i = 0; i < NUM_ENT; i++) tbl_q[i] <= ENTRY_RST;
        end else begin
            fsm_q   <= fsm_d;
            n_q     <= n_d;
            ent_q   <= ent_d;
            phase_q <= phase_d;
            tptr_q  <= tptr_d;
            tape_q  <= tape_d;
            head_q  <= head_d;
            st_q    <= st_d;
            for (int i = 0; i < NUM_ENT; i++) tbl_q[i] <= tbl_d[i];
        end
    end

    // display[i] shows cell head+5-i
    always_comb begin
        int idx;
        display = '0;
        for (int i = 0; i < 11; i++) begin
            idx = int'(head_q) + 5 - i;
`ifdef TM_TAPE_WRAP_EN
            idx = (idx + TAPE_LEN) % TAPE_LEN;
            display[i] = tape_q[idx[HW-1:0]];
`else
            if (idx >= 0 && idx < TAPE_LEN) display[i] = tape_q[idx[HW-1:0]];
`endif
        end
    end

    assign Compute_done = (fsm_q == HALT);

endmodule

// File: tb/tb_turing_machine.sv
// Directed bench for turing_machine: unary adder table, strobe corners, reset, tape edge.
module tb_turing_machine;
    localparam int DATA_W   = 4;
    localparam int TAPE_LEN = 64;
    localparam int HOME     = TAPE_LEN / 2;

    logic              clock = 1'b0;
    logic              Reset_n = 1'b0;
    logic [DATA_W-1:0] input_data = '0;
    logic              Next = 1'b0;
    logic              Done = 1'b0;
    logic [10:0]       display;
    logic              Compute_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] disp;
        logic        cd;
    } exp_t;

    exp_t ev [11];
    int   tbl_w [18] = '{1,1,2, 1,1,1, 0,0,3, 1,1,2, 0,2,3, 0,2,3};
    int   tape_w [9] = '{1,1,1,1,0,1,1,1,0};

    always #5 clock = ~clock;

    turing_machine #(.DATA_W(DATA_W), .TAPE_LEN(TAPE_LEN)) dut (
        .clock(clock), .Reset_n(Reset_n), .input_data(input_data),
        .Next(Next), .Done(Done), .display(display), .Compute_done(Compute_done)
    );

    task automatic chk(input string name, input logic [10:0] ed, input logic ecd);
        checks++;
        if (display !== ed) begin
            errors++;
            $display("FAIL %s display got %b want %b", name, display, ed);
        end
        checks++;
        if (Compute_done !== ecd) begin
            errors++;
            $display("FAIL %s Compute_done got %b want %b", name, Compute_done, ecd);
        end
    endtask

    task automatic next_pulse(input int d, input bit with_done);
        @(negedge clock);
        input_data = DATA_W'(d);
        Next = 1'b1;
        Done = with_done;
        @(negedge clock);
        Next = 1'b0;
        Done = 1'b0;
    endtask

    task automatic done_pulse();
        @(negedge clock);
        Done = 1'b1;
        @(negedge clock);
        Done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        Reset_n = 1'b0;
        repeat (2) @(negedge clock);
        Reset_n = 1'b1;
    endtask

    // merge_done: final tape word shares its cycle with Done
    task automatic load_unary(input bit merge_done);
        next_pulse(3, 0);
        for (int i = 0; i < 18; i++) next_pulse(tbl_w[i], 0);
        if (merge_done) begin
            for (int i = 0; i < 7; i++) next_pulse(tape_w[i], 0);
            next_pulse(tape_w[7], 1);
        end else begin
            for (int i = 0; i < 9; i++) next_pulse(tape_w[i], 0);
            done_pulse();
        end
    endtask

    initial begin
        ev[0]  = '{11'b00000_1_11101, 1'b0};
        ev[1]  = '{11'b00001_1_11011, 1'b0};
        ev[2]  = '{11'b00011_1_10111, 1'b0};
        ev[3]  = '{11'b00111_1_01110, 1'b0};
        ev[4]  = '{11'b01111_0_11100, 1'b0};
        ev[5]  = '{11'b11111_1_11000, 1'b0};
        ev[6]  = '{11'b11111_1_10000, 1'b0};
        ev[7]  = '{11'b11111_1_00000, 1'b0};
        ev[8]  = '{11'b11111_0_00000, 1'b0};
        ev[9]  = '{11'b11111_1_00000, 1'b0};
        ev[10] = '{11'b11111_0_00000, 1'b1};

        repeat (2) @(negedge clock);
        chk("reset", 11'b0, 1'b0);
        Reset_n = 1'b1;

        // unary adder, first step with Next held for five cycles
        load_unary(0);
        chk("loaded", ev[0].disp, ev[0].cd);
        @(negedge clock);
        Next = 1'b1;
        repeat (5) @(negedge clock);
        Next = 1'b0;
        chk("held_next", ev[1].disp, ev[1].cd);
        for (int s = 2; s <= 10; s++) begin
            next_pulse(0, 0);
            chk($sformatf("step%0d", s), ev[s].disp, ev[s].cd);
        end
        for (int k = 0; k < 3; k++) next_pulse(15, 0);
        done_pulse();
        chk("post_halt", ev[10].disp, ev[10].cd);

        // reload with merged Next+Done, then async reset mid-run
        do_reset();
        load_unary(1);
        chk("merged_done", ev[0].disp, ev[0].cd);
        for (int s = 1; s <= 3; s++) next_pulse(0, 0);
        chk("pre_reset", ev[3].disp, ev[3].cd);
        @(posedge clock);
        #2 Reset_n = 1'b0;
        #1 chk("async_reset", 11'b0, 1'b0);
        @(negedge clock);
        Reset_n = 1'b1;
        load_unary(0);
        chk("reload", ev[0].disp, ev[0].cd);
        for (int s = 1; s <= 10; s++) begin
            next_pulse(0, 0);
            chk($sformatf("rerun%0d", s), ev[s].disp, ev[s].cd);
        end

        // empty table: first step writes 0 and halts
        do_reset();
        next_pulse(1, 0);
        done_pulse();
        chk("n1_run", 11'b0, 1'b0);
        next_pulse(0, 0);
        chk("n1_halt", 11'b0, 1'b1);

        // always-left program, writes 1 on every cell it leaves
        do_reset();
        next_pulse(1, 0);
        for (int i = 0; i < 2; i++) begin
            next_pulse(1, 0);
            next_pulse(0, 0);
            next_pulse(1, 0);
        end
        done_pulse();
        chk("left_init", 11'b0, 1'b0);
        for (int s = 0; s < HOME; s++) next_pulse(0, 0);
        chk("left_at0", 11'b00000_0_11111, 1'b0);
        next_pulse(0, 0);
`ifdef TM_TAPE_WRAP_EN
        chk("left_wrap", 11'b00000_0_11111, 1'b0);
        for (int s = 0; s < 10; s++) next_pulse(0, 0);
        chk("left_wrap_run", 11'b00000_0_11111, 1'b0);
`else
        chk("left_edge", 11'b00000_1_11111, 1'b1);
        next_pulse(0, 0);
        chk("left_edge_hold", 11'b00000_1_11111, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout display got %b want finish", display);
        $fatal(1, "timeout");
    end
endmodule
